led_mode_uart_tx: RTL



---
 rtl/led_mode_uart_pkg.sv | 41 ++++
 rtl/led_mode_uart_tx_byte.sv | 69 ++++++
 rtl/led_mode_uart_tx.sv | 108 ++++++++++
 3 files changed

// File: rtl/led_mode_uart_pkg.sv
// Constants shared by the LED-mode UART transmit and receive paths: code-byte map, frame trailer,
// baud divider, and the state/struct types used by the transmitter.
package led_mode_uart_pkg;

  localparam logic [7:0] FRAME_TRAILER    = 8'hCC;
  localparam logic [7:0] CODE_BASE_DIG    = 8'h30;
  localparam logic [7:0] CODE_BASE_TEN    = 8'h40;
  localparam logic [7:0] CODE_BASE_TWENTY = 8'h20;
  localparam logic [4:0] MODE_LIM_DIG     = 5'd9;
  localparam logic [4:0] MODE_LIM_TEN     = 5'd19;
  localparam logic [4:0] MODE_LIM_TWENTY  = 5'd24;
  localparam int         FRAME_BYTES      = 3;

  typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} bit_state_t;
  typedef enum logic [1:0] {FR_IDLE, FR_SEND, FR_DONE} frame_state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] code;
  } mode_code_t;

  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic mode_code_t encode_mode(input logic [4:0] mode);
    mode_code_t r;
    r.vld  = 1'b1;
    r.code = 8'h00;
    if (mode <= MODE_LIM_DIG)
      r.code = CODE_BASE_DIG + {3'b000, mode};
    else if (mode <= MODE_LIM_TEN)
      r.code = CODE_BASE_TEN + {3'b000, mode - (MODE_LIM_DIG + 5'd1)};
    else if (mode <= MODE_LIM_TWENTY)
      r.code = CODE_BASE_TWENTY + {3'b000, mode - (MODE_LIM_TEN + 5'd1)};
    else
      r.vld = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/led_mode_uart_tx_byte.sv
// 8N1 byte serialiser: start bit on the line the cycle after i_start&&o_rdy, BPS_CNT cycles per bit.
// o_rdy is high in idle and in the last stop-bit cycle, so back-to-back bytes have no gap.
module uart_byte_tx
  import led_mode_uart_pkg::*;
#(
  parameter int BPS_CNT = 5208
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_rdy,
  output logic       o_txd
);

  localparam int            CW        = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BPS_CNT - 1);

  bit_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_bit_end;

  assign w_bit_end = (r_state != BIT_IDLE) && (r_baud == BAUD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= BIT_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BIT_IDLE:  if (i_start) w_state_nxt = BIT_START;
      BIT_START: if (w_bit_end) w_state_nxt = BIT_DATA;
      BIT_DATA:  if (w_bit_end && r_bit == 3'd7) w_state_nxt = BIT_STOP;
      BIT_STOP:  if (w_bit_end) w_state_nxt = i_start ? BIT_START : BIT_IDLE;
      default:   w_state_nxt = BIT_IDLE;
    endcase
  end

  always_comb begin
    o_rdy = 1'b0;
    o_txd = 1'b1;
    case (r_state)
      BIT_IDLE:  o_rdy = 1'b1;
      BIT_START: o_txd = 1'b0;
      BIT_DATA:  o_txd = r_shift[r_bit];
      BIT_STOP:  o_rdy = w_bit_end;
      default:   o_txd = 1'b1;
    endcase
  end

  // Baud counter wraps at every bit boundary; bit counter wraps 7->0 leaving DATA.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (r_state == BIT_IDLE || w_bit_end) r_baud <= '0;
      else                                  r_baud <= r_baud + 1'b1;
      if (r_state == BIT_DATA && w_bit_end) r_bit <= r_bit + 3'd1;
      if (i_start && o_rdy)                 r_shift <= i_data;
    end
  end

endmodule

// File: rtl/led_mode_uart_tx.sv
// LED-mode reporter: encodes mode 0-24 into {code,0xCC,0xCC} and sends it 8N1; line goes low the cycle
// after an accepted request. Requests while busy land in a one-deep, overwrite-latest pending slot.
module led_mode_uart_tx
  import led_mode_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [4:0] mode_in,
  input  logic       mode_vld,
  output logic       uart_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       mode_err
);

  localparam int         BPS_CNT  = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

  frame_state_t r_state, w_state_nxt;
  logic [1:0]   r_idx;
  logic         r_pend_vld;
  logic [7:0]   r_pend_code;
  logic         r_mode_err;
  mode_code_t   w_enc;
  logic         w_req_ok, w_req_bad, w_tx_start, w_tx_rdy, w_last_byte, w_done_go;
  logic [7:0]   w_tx_data, w_done_code;

  assign w_enc       = encode_mode(mode_in);
  assign w_req_ok    = mode_vld & w_enc.vld;
  assign w_req_bad   = mode_vld & ~w_enc.vld;
  assign w_last_byte = (r_state == FR_SEND) && w_tx_rdy && (r_idx == LAST_IDX);
  // A request arriving in DONE is newer than the slot, so it wins.
  assign w_done_go   = w_req_ok | r_pend_vld;
  assign w_done_code = w_req_ok ? w_enc.code : r_pend_code;
  assign mode_err    = r_mode_err;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= FR_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FR_IDLE: if (w_req_ok) w_state_nxt = FR_SEND;
      FR_SEND: if (w_last_byte) w_state_nxt = FR_DONE;
      FR_DONE: w_state_nxt = w_done_go ? FR_SEND : FR_IDLE;
      default: w_state_nxt = FR_IDLE;
    endcase
  end

  always_comb begin
    w_tx_start = 1'b0;
    w_tx_data  = FRAME_TRAILER;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      FR_IDLE: begin
        w_tx_start = w_req_ok;
        w_tx_data  = w_enc.code;
      end
      FR_SEND: begin
        w_tx_start = w_tx_rdy && (r_idx != LAST_IDX);
        busy       = 1'b1;
      end
      FR_DONE: begin
        w_tx_start = w_done_go;
        w_tx_data  = w_done_code;
        busy       = r_pend_vld;
        frame_done = 1'b1;
      end
      default: w_tx_start = 1'b0;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_idx       <= 2'd0;
      r_pend_vld  <= 1'b0;
      r_pend_code <= 8'h00;
      r_mode_err  <= 1'b0;
    end else begin
      r_mode_err <= w_req_bad;
      if (r_state != FR_SEND)           r_idx <= 2'd0;
      else if (w_tx_rdy)                r_idx <= (r_idx == LAST_IDX) ? 2'd0 : r_idx + 2'd1;
      if (r_state == FR_DONE)           r_pend_vld <= 1'b0;
      else if (r_state == FR_SEND && w_req_ok) begin
        r_pend_vld  <= 1'b1;
        r_pend_code <= w_enc.code;
      end
    end
  end

  uart_byte_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_byte_tx (
    .i_clk   (I_clk),
    .i_rst_n (I_rst_n),
    .i_start (w_tx_start),
    .i_data  (w_tx_data),
    .o_rdy   (w_tx_rdy),
    .o_txd   (uart_txd)
  );

endmodule
